// File: rtl/rs232_pkg.sv
// Shared types and helpers for the configurable RS-232 transmitter.
// Frame FSM states, parity mode codes and the baud increment calculation.
package rs232_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_BREAK,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP1,
        S_STOP2
    } state_t;

    localparam logic [2:0] PAR_NONE  = 3'd0;
    localparam logic [2:0] PAR_EVEN  = 3'd1;
    localparam logic [2:0] PAR_ODD   = 3'd2;
    localparam logic [2:0] PAR_MARK  = 3'd3;
    localparam logic [2:0] PAR_SPACE = 3'd4;

    // Rounded fractional increment; 64-bit to keep the shift exact.
    function automatic int unsigned baud_inc(
        input longint unsigned clk_f,
        input longint unsigned baud,
        input int              w
    );
        longint unsigned num;
        num = (baud << (w - 4)) + (clk_f >> 5);
        return int'(num / (clk_f >> 4));
    endfunction

endpackage

// File: rtl/rs232_tx_cfg_if.sv
// Producer-side handshake and per-frame format for the RS-232 transmitter.
// The master drives data/config/ready; the transmitter returns tx_accept.
interface rs232_tx_cfg_if #(
    parameter int MAX_DATA_BITS = 9
);
    logic [MAX_DATA_BITS-1:0] tx_datain;
    logic                     tx_datain_ready;
    logic                     tx_accept;
    logic [3:0]               cfg_data_bits;
    logic [2:0]               cfg_parity;
    logic                     cfg_stop2;

    modport master (
        output tx_datain,
        output tx_datain_ready,
        output cfg_data_bits,
        output cfg_parity,
        output cfg_stop2,
        input  tx_accept
    );

    modport slave (
        input  tx_datain,
        input  tx_datain_ready,
        input  cfg_data_bits,
        input  cfg_parity,
        input  cfg_stop2,
        output tx_accept
    );
endinterface

// File: rtl/rs232_baud_gen.sv
// Fractional baud accumulator; pulse marks the cycle the add carries out.
// Shared between transmitter and any future receiver.
module rs232_baud_gen #(
    parameter int          W   = 16,
    parameter int unsigned INC = 4096
) (
    input  logic clock,
    input  logic reset_neg,
    input  logic clr,
    input  logic en,
    output logic pulse
);
    localparam logic [W:0] INC_W = (W+1)'(INC);

    logic [W-1:0] acc;
    logic [W:0]   sum;

    assign sum   = {1'b0, acc} + INC_W;
    assign pulse = en & sum[W];

    always_ff @(posedge clock or negedge reset_neg) begin
        if (!reset_neg) begin
            acc <= '0;
        end else if (clr) begin
            acc <= '0;
        end else if (en) begin
            acc <= sum[W-1:0];
        end
    end
endmodule

// File: rtl/rs232_tx_cfg.sv
// Runtime-configurable RS-232 transmitter: 5..9 data bits, parity modes,
// 1/2 stop bits and break, serialised LSB first on a registered line.
module rs232_tx_cfg
    import rs232_pkg::*;
#(
    parameter int unsigned CLOCK_FREQ     = 100000000,
    parameter int unsigned BAUD_RATE      = 115200,
    parameter int          BAUD_ACC_WIDTH = 16,
    parameter int          MAX_DATA_BITS  = 9,
    parameter bit          REG_INPUT      = 1'b1
) (
    input  logic               clock,
    input  logic               reset_neg,
    input  logic               Present_Processing_Completed,
    rs232_tx_cfg_if.slave      txi,
    input  logic               tx_break,
    output logic               tx_transmitter,
    output logic               tx_transmitter_valid,
    output logic               tx_done
);
    localparam int unsigned INC =
        baud_inc(CLOCK_FREQ, BAUD_RATE, BAUD_ACC_WIDTH);
    localparam logic [3:0] MAXB = 4'(MAX_DATA_BITS);

    state_t                   state, state_n;
    logic [3:0]               idx, idx_n;
    logic [MAX_DATA_BITS-1:0] data_q, data_use, mask;
    logic [3:0]               nbits_q, nbits_c;
    logic [2:0]               par_q;
    logic                     stop2_q;
    logic                     accept, pulse, par_en, par_bit, line_c;
    logic                     in_frame, in_frame_n;

    assign txi.tx_accept = (state == S_IDLE);
    assign accept   = txi.tx_accept & txi.tx_datain_ready;
    assign data_use = REG_INPUT ? data_q : txi.tx_datain;
    assign in_frame   = !(state inside {S_IDLE, S_BREAK});
    assign in_frame_n = !(state_n inside {S_IDLE, S_BREAK});

    rs232_baud_gen #(
        .W   (BAUD_ACC_WIDTH),
        .INC (INC)
    ) u_baud (
        .clock     (clock),
        .reset_neg (reset_neg),
        .clr       (accept | Present_Processing_Completed),
        .en        (in_frame),
        .pulse     (pulse)
    );

    always_comb begin
        nbits_c = txi.cfg_data_bits;
        if (nbits_c < 4'd5) nbits_c = 4'd5;
        else if (nbits_c > MAXB) nbits_c = MAXB;
    end

    always_comb begin
        mask = '0;
        for (int i = 0; i < MAX_DATA_BITS; i++)
            mask[i] = (i < int'(nbits_q));
    end

    always_comb begin
        par_en  = 1'b1;
        par_bit = 1'b0;
        case (par_q)
            PAR_EVEN:  par_bit = ^(data_use & mask);
            PAR_ODD:   par_bit = ~^(data_use & mask);
            PAR_MARK:  par_bit = 1'b1;
            PAR_SPACE: par_bit = 1'b0;
            PAR_NONE:  par_en  = 1'b0;
            default:   par_en  = 1'b0;
        endcase
    end

    always_comb begin
        state_n = state;
        idx_n   = idx;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    state_n = S_START;
                    idx_n   = '0;
                end else if (tx_break) begin
                    state_n = S_BREAK;
                end
            end
            S_BREAK:
                if (!tx_break) state_n = S_IDLE;
            S_START:
                if (pulse) state_n = S_DATA;
            S_DATA:
                if (pulse) begin
                    if (idx == nbits_q - 4'd1)
                        state_n = par_en ? S_PARITY : S_STOP1;
                    else
                        idx_n = idx + 4'd1;
                end
            S_PARITY:
                if (pulse) state_n = S_STOP1;
            S_STOP1:
                if (pulse) state_n = stop2_q ? S_STOP2 : S_IDLE;
            S_STOP2:
                if (pulse) state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    always_comb begin
        line_c = 1'b1;
        case (state)
            S_BREAK, S_START: line_c = 1'b0;
            S_DATA:           line_c = data_use[idx];
            S_PARITY:         line_c = par_bit;
            default:          line_c = 1'b1;
        endcase
    end

    always_ff @(posedge clock or negedge reset_neg) begin
        if (!reset_neg) begin
            state                <= S_IDLE;
            idx                  <= '0;
            data_q               <= '1;
            nbits_q              <= 4'd8;
            par_q                <= PAR_NONE;
            stop2_q              <= 1'b0;
            tx_transmitter       <= 1'b1;
            tx_transmitter_valid <= 1'b0;
            tx_done              <= 1'b0;
        end else if (Present_Processing_Completed) begin
            state                <= S_IDLE;
            idx                  <= '0;
            data_q               <= '1;
            tx_transmitter       <= 1'b1;
            tx_transmitter_valid <= 1'b0;
            tx_done              <= 1'b0;
        end else begin
            state <= state_n;
            idx   <= idx_n;
            if (accept) begin
                data_q  <= txi.tx_datain;
                nbits_q <= nbits_c;
                par_q   <= txi.cfg_parity;
                stop2_q <= txi.cfg_stop2;
            end
            // Line lags the state by one clock so it is a clean flop output.
            tx_transmitter       <= line_c;
            tx_transmitter_valid <= in_frame_n;
            tx_done              <= in_frame && (state_n == S_IDLE);
        end
    end
endmodule

// File: tb/tb_rs232_tx_cfg.sv
// Self-checking bench for rs232_tx_cfg at 16 clocks per bit.
// Directed table, hand sequences and randomized frames vs a frame model.
module tb_rs232_tx_cfg;
    localparam int BIT = 16;

    logic clock = 1'b0;
    logic reset_neg;
    logic ppc;
    logic tx_break;
    logic tx_transmitter, tx_transmitter_valid, tx_done;

    int errors = 0;
    int checks = 0;

    always #5 clock = ~clock;

    rs232_tx_cfg_if #(.MAX_DATA_BITS(9)) bus ();

    rs232_tx_cfg #(
        .CLOCK_FREQ     (1600000),
        .BAUD_RATE      (100000),
        .BAUD_ACC_WIDTH (16),
        .MAX_DATA_BITS  (9),
        .REG_INPUT      (1'b1)
    ) dut (
        .clock                        (clock),
        .reset_neg                    (reset_neg),
        .Present_Processing_Completed (ppc),
        .txi                          (bus),
        .tx_break                     (tx_break),
        .tx_transmitter               (tx_transmitter),
        .tx_transmitter_valid         (tx_transmitter_valid),
        .tx_done                      (tx_done)
    );

    typedef struct {
        logic [8:0]  d;
        logic [3:0]  nb;
        logic [2:0]  p;
        bit          s2;
        bit          brk;
        int          len;
        logic [15:0] f;
    } vec_t;

    vec_t tbl[8];

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    // Frame as a list of line bits, built straight from the format rules.
    function automatic void model_frame(
        input  logic [8:0]  d,
        input  int          nb,
        input  int          p,
        input  bit          s2,
        output logic [15:0] f,
        output int          len
    );
        bit q[$];
        int n;
        int ones;
        n = nb;
        if (n < 5) n = 5;
        if (n > 9) n = 9;
        ones = 0;
        q.push_back(1'b0);
        for (int i = 0; i < n; i++) begin
            q.push_back(d[i]);
            ones += int'(d[i]);
        end
        case (p)
            1: q.push_back(bit'(ones % 2));
            2: q.push_back(bit'(1 - ones % 2));
            3: q.push_back(1'b1);
            4: q.push_back(1'b0);
            default: ;
        endcase
        q.push_back(1'b1);
        if (s2) q.push_back(1'b1);
        f = '0;
        foreach (q[i]) f[i] = q[i];
        len = q.size();
    endfunction

    // Leaves the bench on the first falling edge after the accept edge.
    task automatic start_frame(
        input logic [8:0] d,
        input logic [3:0] nb,
        input logic [2:0] p,
        input bit         s2,
        input bit         brk
    );
        int w;
        w = 0;
        @(negedge clock);
        bus.tx_datain       = d;
        bus.cfg_data_bits   = nb;
        bus.cfg_parity      = p;
        bus.cfg_stop2       = s2;
        bus.tx_datain_ready = 1'b1;
        tx_break            = brk;
        while (!bus.tx_accept && w < 300) begin
            @(negedge clock);
            w++;
        end
        chk("accept_wait", int'(w < 300), 1);
        @(negedge clock);
    endtask

    task automatic check_frame(
        input logic [15:0] f,
        input int          len,
        input string       nm,
        input bit          hold
    );
        int last;
        int lerr;
        int vcnt;
        int dcnt;
        int dpos;
        logic exp_l;
        last = len * BIT;
        lerr = 0;
        vcnt = 0;
        dcnt = 0;
        dpos = -1;
        for (int n = 0; n <= last + 1; n++) begin
            if (n == 0) exp_l = 1'b1;
            else if (n <= last) exp_l = f[(n - 1) / BIT];
            else exp_l = 1'b1;
            if (tx_transmitter !== exp_l) begin
                if (lerr == 0)
                    $display("FAIL %s line at clk %0d: got %b, expected %b",
                             nm, n, tx_transmitter, exp_l);
                lerr++;
            end
            if (n <= last && tx_transmitter_valid === 1'b1) vcnt++;
            if (tx_done === 1'b1) begin
                dcnt++;
                dpos = n;
            end
            if (n == 0) begin
                tx_break = 1'b0;
                if (!hold) begin
                    bus.tx_datain_ready = 1'b0;
                    bus.tx_datain       = 9'($urandom_range(0, 511));
                    bus.cfg_data_bits   = 4'($urandom_range(0, 15));
                    bus.cfg_parity      = 3'($urandom_range(0, 7));
                    bus.cfg_stop2       = 1'($urandom_range(0, 1));
                end
            end
            if (n < last + 1) @(negedge clock);
        end
        chk({nm, " line_errs"}, lerr, 0);
        chk({nm, " valid_clks"}, vcnt, last);
        chk({nm, " done_count"}, dcnt, 1);
        chk({nm, " done_pos"}, dpos, last);
    endtask

    task automatic run_vec(input vec_t v, input string nm);
        start_frame(v.d, v.nb, v.p, v.s2, v.brk);
        check_frame(v.f, v.len, nm, 1'b0);
    endtask

    initial begin
        logic [15:0] fa, fb, fr;
        int la, lb, lr;
        int lows, nacc, vh, dn;
        logic [8:0] rd;
        int rnb, rp;
        bit rs2;

        tbl[0] = '{9'h055, 4'd8,  3'd0, 1'b0, 1'b0, 10,
                   16'({1'b1, 8'h55, 1'b0})};
        tbl[1] = '{9'h041, 4'd7,  3'd1, 1'b1, 1'b0, 11,
                   16'({2'b11, 1'b0, 7'h41, 1'b0})};
        tbl[2] = '{9'h0A5, 4'd8,  3'd2, 1'b0, 1'b0, 11,
                   16'({1'b1, 1'b1, 8'hA5, 1'b0})};
        tbl[3] = '{9'h1FF, 4'd9,  3'd3, 1'b0, 1'b0, 12,
                   16'({1'b1, 1'b1, 9'h1FF, 1'b0})};
        tbl[4] = '{9'h0FF, 4'd3,  3'd1, 1'b0, 1'b0, 8,
                   16'({1'b1, 1'b1, 5'h1F, 1'b0})};
        tbl[5] = '{9'h100, 4'd15, 3'd4, 1'b1, 1'b0, 13,
                   16'({2'b11, 1'b0, 9'h100, 1'b0})};
        tbl[6] = '{9'h3A5, 4'd6,  3'd7, 1'b0, 1'b0, 8,
                   16'({1'b1, 6'h25, 1'b0})};
        tbl[7] = '{9'h000, 4'd8,  3'd1, 1'b0, 1'b1, 11,
                   16'({1'b1, 1'b0, 8'h00, 1'b0})};

        reset_neg           = 1'b0;
        ppc                 = 1'b0;
        tx_break            = 1'b0;
        bus.tx_datain       = '0;
        bus.tx_datain_ready = 1'b0;
        bus.cfg_data_bits   = 4'd8;
        bus.cfg_parity      = 3'd0;
        bus.cfg_stop2       = 1'b0;
        repeat (3) @(negedge clock);
        chk("rst line", int'(tx_transmitter), 1);
        chk("rst valid", int'(tx_transmitter_valid), 0);
        chk("rst done", int'(tx_done), 0);
        chk("rst accept", int'(bus.tx_accept), 1);
        reset_neg = 1'b1;

        foreach (tbl[i]) run_vec(tbl[i], $sformatf("vec%0d", i));

        // Back-to-back frames with ready held high.
        model_frame(9'h03C, 8, 0, 1'b0, fa, la);
        model_frame(9'h0C3, 8, 0, 1'b0, fb, lb);
        start_frame(9'h03C, 4'd8, 3'd0, 1'b0, 1'b0);
        bus.tx_datain = 9'h0C3;
        check_frame(fa, la, "b2b_a", 1'b1);
        check_frame(fb, lb, "b2b_b", 1'b0);

        // Synchronous clear in the middle of the data bits.
        start_frame(9'h0A5, 4'd8, 3'd0, 1'b0, 1'b0);
        bus.tx_datain_ready = 1'b0;
        repeat (40) @(negedge clock);
        ppc = 1'b1;
        @(negedge clock);
        ppc = 1'b0;
        chk("clr line", int'(tx_transmitter), 1);
        chk("clr valid", int'(tx_transmitter_valid), 0);
        chk("clr done", int'(tx_done), 0);
        lows = 0;
        dn   = 0;
        repeat (200) begin
            @(negedge clock);
            if (tx_transmitter !== 1'b1) lows++;
            if (tx_done === 1'b1) dn++;
        end
        chk("clr quiet_lows", lows, 0);
        chk("clr quiet_done", dn, 0);
        run_vec(tbl[2], "after_clr");

        // Asynchronous reset in the middle of the data bits.
        start_frame(9'h0F0, 4'd8, 3'd1, 1'b0, 1'b0);
        bus.tx_datain_ready = 1'b0;
        repeat (50) @(negedge clock);
        #2 reset_neg = 1'b0;
        #1;
        chk("arst line", int'(tx_transmitter), 1);
        chk("arst valid", int'(tx_transmitter_valid), 0);
        @(negedge clock);
        reset_neg = 1'b1;
        run_vec(tbl[0], "after_arst");

        // Break held for 100 clocks while idle.
        @(negedge clock);
        bus.tx_datain_ready = 1'b0;
        tx_break = 1'b1;
        lows = 0;
        nacc = 0;
        vh   = 0;
        for (int n = 0; n < 106; n++) begin
            @(negedge clock);
            if (tx_transmitter === 1'b0) lows++;
            if (bus.tx_accept === 1'b0) nacc++;
            if (tx_transmitter_valid === 1'b1) vh++;
            if (n == 99) tx_break = 1'b0;
        end
        chk("brk low_clks", lows, 100);
        chk("brk noaccept_clks", nacc, 100);
        chk("brk valid_clks", vh, 0);
        chk("brk end_line", int'(tx_transmitter), 1);
        run_vec(tbl[1], "after_brk");

        // Randomized formats against the frame model.
        for (int k = 0; k < 16; k++) begin
            rd  = 9'($urandom_range(0, 511));
            rnb = int'($urandom_range(0, 15));
            rp  = int'($urandom_range(0, 7));
            rs2 = 1'($urandom_range(0, 1));
            model_frame(rd, rnb, rp, rs2, fr, lr);
            start_frame(rd, 4'(rnb), 3'(rp), rs2, 1'b0);
            check_frame(fr, lr, $sformatf("rnd%0d", k), 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
